// File: rtl/mem_pkg.sv
// Shared types and helpers for the M-stage memory access unit.
// Holds the load/store op encoding, FSM states and bus width helpers.
package mem_pkg;

    typedef enum logic [3:0] {
        OP_NONE = 4'd0,
        OP_LB   = 4'd1,
        OP_LBU  = 4'd2,
        OP_LH   = 4'd3,
        OP_LHU  = 4'd4,
        OP_LW   = 4'd5,
        OP_SB   = 4'd6,
        OP_SH   = 4'd7,
        OP_SW   = 4'd8
    } mem_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DONE
    } state_e;

    typedef enum logic [1:0] {
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD
    } size_e;

    function automatic int mem_lanes(input int data_w);
        return data_w / 8;
    endfunction

    function automatic int mem_off_w(input int data_w);
        return $clog2(data_w / 8);
    endfunction

    function automatic logic op_is_load(input mem_op_e op);
        return op inside {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW};
    endfunction

    function automatic logic op_is_store(input mem_op_e op);
        return op inside {OP_SB, OP_SH, OP_SW};
    endfunction

    function automatic size_e op_size(input mem_op_e op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return SZ_BYTE;
            OP_LH, OP_LHU, OP_SH: return SZ_HALF;
            default:              return SZ_WORD;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_load_extend.sv
// Load lane select plus sign/zero extension of returned bus data.
// Ports: rdata (bus word), op (load op), offset (byte lane) -> data.
module load_extend
    import mem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int OFF_W  = 2
) (
    input  logic [DATA_W-1:0] rdata,
    input  mem_op_e           op,
    input  logic [OFF_W-1:0]  offset,
    output logic [DATA_W-1:0] data
);

    logic [DATA_W-1:0] lane;

    always_comb begin
        lane = rdata >> {offset, 3'b000};
        case (op)
            OP_LB:   data = DATA_W'($signed(lane[7:0]));
            OP_LBU:  data = DATA_W'(lane[7:0]);
            OP_LH:   data = DATA_W'($signed(lane[15:0]));
            OP_LHU:  data = DATA_W'(lane[15:0]);
            OP_LW:   data = DATA_W'($signed(lane[31:0]));
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// M-stage memory access unit: alignment check, registered bus request,
// pipeline stall, timeout and extended load return.
// Ports: req_* from M stage; stall/rd_*/exc_* to pipeline; m_* to memory.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        req_valid,
    input  logic [3:0]                  req_op,
    input  logic [ADDR_W-1:0]           req_addr,
    input  logic [DATA_W-1:0]           req_wdata,
    output logic                        stall,
    output logic                        rd_valid,
    output logic [DATA_W-1:0]           rd_data,
    output logic                        exc_adel,
    output logic                        exc_ades,
    output logic                        exc_bus,
    output logic                        m_req,
    output logic                        m_we,
    output logic [ADDR_W-1:0]           m_addr,
    output logic [mem_lanes(DATA_W)-1:0] m_byteen,
    output logic [DATA_W-1:0]           m_wdata,
    input  logic                        m_ack,
    input  logic [DATA_W-1:0]           m_rdata
);

    localparam int LANES = mem_lanes(DATA_W);
    localparam int OFF_W = mem_off_w(DATA_W);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    mem_op_e          op_in;
    size_e            sz_in;
    logic [OFF_W-1:0] off_in;
    logic             ld_in;
    logic             st_in;
    logic             aligned;
    logic             accept;
    logic [LANES-1:0] be_in;
    logic [DATA_W-1:0] wmask;
    logic [DATA_W-1:0] ext_data;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              m_req_q, m_req_d;
    logic              m_we_q, m_we_d;
    logic [ADDR_W-1:0] m_addr_q, m_addr_d;
    logic [LANES-1:0]  m_byteen_q, m_byteen_d;
    logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
    mem_op_e           op_q, op_d;
    logic [OFF_W-1:0]  off_q, off_d;
    logic              rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              exc_bus_q, exc_bus_d;

    assign op_in  = mem_op_e'(req_op);
    assign sz_in  = op_size(op_in);
    assign off_in = req_addr[OFF_W-1:0];
    assign ld_in  = op_is_load(op_in);
    assign st_in  = op_is_store(op_in);

    always_comb begin
        aligned = 1'b1;
        be_in   = '0;
        wmask   = '0;
        unique case (1'b1)
            sz_in == SZ_BYTE: begin
                be_in = LANES'(1) << off_in;
                wmask = DATA_W'(8'hFF);
            end
            sz_in == SZ_HALF: begin
                aligned = ~req_addr[0];
                be_in   = LANES'(3) << off_in;
                wmask   = DATA_W'(16'hFFFF);
            end
            default: begin
                aligned = (req_addr[1:0] == 2'b00);
                be_in   = LANES'(15) << off_in;
                wmask   = DATA_W'(32'hFFFF_FFFF);
            end
        endcase
    end

    wire in_idle = (state_q == ST_IDLE);
    wire mem_op  = req_valid & (ld_in | st_in);

    assign accept   = in_idle & mem_op & aligned;
    assign exc_adel = in_idle & req_valid & ld_in & ~aligned;
    assign exc_ades = in_idle & req_valid & st_in & ~aligned;
    assign stall    = accept | (state_q == ST_WAIT);

    load_extend #(
        .DATA_W (DATA_W),
        .OFF_W  (OFF_W)
    ) u_load_extend (
        .rdata  (m_rdata),
        .op     (op_q),
        .offset (off_q),
        .data   (ext_data)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        m_req_d    = m_req_q;
        m_we_d     = m_we_q;
        m_addr_d   = m_addr_q;
        m_byteen_d = m_byteen_q;
        m_wdata_d  = m_wdata_q;
        op_d       = op_q;
        off_d      = off_q;
        rd_valid_d = 1'b0;
        rd_data_d  = rd_data_q;
        exc_bus_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d    = ST_WAIT;
                    cnt_d      = '0;
                    m_req_d    = 1'b1;
                    m_we_d     = st_in;
                    m_addr_d   = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                    m_byteen_d = be_in;
                    m_wdata_d  = (req_wdata & wmask) << {off_in, 3'b000};
                    op_d       = op_in;
                    off_d      = off_in;
                end
            end
            ST_WAIT: begin
                if (m_ack) begin
                    state_d    = ST_DONE;
                    m_req_d    = 1'b0;
                    m_we_d     = 1'b0;
                    rd_valid_d = op_is_load(op_q);
                    if (op_is_load(op_q)) rd_data_d = ext_data;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    // Final waiting cycle: give up and flag a bus error.
                    state_d   = ST_DONE;
                    cnt_d     = cnt_q + 1'b1;
                    m_req_d   = 1'b0;
                    m_we_d    = 1'b0;
                    exc_bus_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            m_req_q    <= 1'b0;
            m_we_q     <= 1'b0;
            m_addr_q   <= '0;
            m_byteen_q <= '0;
            m_wdata_q  <= '0;
            op_q       <= OP_NONE;
            off_q      <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            exc_bus_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            m_req_q    <= m_req_d;
            m_we_q     <= m_we_d;
            m_addr_q   <= m_addr_d;
            m_byteen_q <= m_byteen_d;
            m_wdata_q  <= m_wdata_d;
            op_q       <= op_d;
            off_q      <= off_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            exc_bus_q  <= exc_bus_d;
        end
    end

    assign m_req    = m_req_q;
    assign m_we     = m_we_q;
    assign m_addr   = m_addr_q;
    assign m_byteen = m_byteen_q;
    assign m_wdata  = m_wdata_q;
    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
    assign exc_bus  = exc_bus_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit (32-bit bus, TIMEOUT=4).
// Linear stimulus; every expected value is hand-computed.
module tb_mem_access_unit;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic [3:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        exc_adel;
    logic        exc_ades;
    logic        exc_bus;
    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [3:0]  m_byteen;
    logic [31:0] m_wdata;
    logic        m_ack;
    logic [31:0] m_rdata;

    int checks   = 0;
    int failures = 0;

    mem_access_unit #(
        .DATA_W  (32),
        .ADDR_W  (32),
        .TIMEOUT (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_op    (req_op),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .stall     (stall),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .exc_adel  (exc_adel),
        .exc_ades  (exc_ades),
        .exc_bus   (exc_bus),
        .m_req     (m_req),
        .m_we      (m_we),
        .m_addr    (m_addr),
        .m_byteen  (m_byteen),
        .m_wdata   (m_wdata),
        .m_ack     (m_ack),
        .m_rdata   (m_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] d);
        req_valid = v;
        req_op    = op;
        req_addr  = a;
        req_wdata = d;
        #1;
    endtask

    initial begin
        reset = 1'b1;
        m_ack = 1'b0;
        m_rdata = '0;
        drive(1'b0, OP_NONE, 32'h0, 32'h0);
        tick();
        tick();
        chk("rst_m_req", m_req, 0);
        chk("rst_m_we", m_we, 0);
        chk("rst_m_addr", m_addr, 0);
        chk("rst_m_byteen", m_byteen, 0);
        chk("rst_m_wdata", m_wdata, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_exc_bus", exc_bus, 0);
        chk("rst_stall", stall, 0);
        chk("rst_adel", exc_adel, 0);
        chk("rst_ades", exc_ades, 0);
        reset = 1'b0;

        // SW 0x1004, ack in cycle 1
        tick();
        drive(1'b1, OP_SW, 32'h1004, 32'hDEAD_BEEF);
        chk("sw_c0_stall", stall, 1);
        chk("sw_c0_ades", exc_ades, 0);
        chk("sw_c0_m_req", m_req, 0);
        tick();
        chk("sw_c1_m_req", m_req, 1);
        chk("sw_c1_m_we", m_we, 1);
        chk("sw_c1_m_addr", m_addr, 32'h1004);
        chk("sw_c1_byteen", m_byteen, 4'b1111);
        chk("sw_c1_wdata", m_wdata, 32'hDEAD_BEEF);
        chk("sw_c1_stall", stall, 1);
        m_ack = 1'b1;
        tick();
        m_ack = 1'b0;
        chk("sw_c2_m_req", m_req, 0);
        chk("sw_c2_stall", stall, 0);
        chk("sw_c2_rd_valid", rd_valid, 0);
        tick();
        drive(1'b0, OP_NONE, 32'h0, 32'h0);
        chk("sw_c3_m_req", m_req, 0);

        // LB 0x2003, ack in cycle 3
        tick();
        drive(1'b1, OP_LB, 32'h2003, 32'h0);
        chk("lb_c0_stall", stall, 1);
        tick();
        chk("lb_c1_byteen", m_byteen, 4'b1000);
        chk("lb_c1_m_addr", m_addr, 32'h2000);
        chk("lb_c1_m_we", m_we, 0);
        tick();
        chk("lb_c2_stall", stall, 1);
        chk("lb_c2_m_req", m_req, 1);
        tick();
        m_rdata = 32'h8012_3456;
        m_ack = 1'b1;
        tick();
        m_ack = 1'b0;
        chk("lb_c4_rd_valid", rd_valid, 1);
        chk("lb_c4_rd_data", rd_data, 32'hFFFF_FF80);
        chk("lb_c4_stall", stall, 0);
        tick();
        drive(1'b0, OP_NONE, 32'h0, 32'h0);
        chk("lb_c5_rd_valid", rd_valid, 0);
        chk("lb_c5_rd_hold", rd_data, 32'hFFFF_FF80);

        // LBU 0x2003, ack in cycle 1
        tick();
        drive(1'b1, OP_LBU, 32'h2003, 32'h0);
        tick();
        m_ack = 1'b1;
        tick();
        m_ack = 1'b0;
        chk("lbu_rd_valid", rd_valid, 1);
        chk("lbu_rd_data", rd_data, 32'h0000_0080);
        tick();
        drive(1'b0, OP_NONE, 32'h0, 32'h0);

        // LH 0x6002 sign-extends the upper halfword
        tick();
        drive(1'b1, OP_LH, 32'h6002, 32'h0);
        tick();
        m_rdata = 32'h8001_1234;
        m_ack = 1'b1;
        tick();
        m_ack = 1'b0;
        chk("lh_rd_data", rd_data, 32'hFFFF_8001);
        tick();
        drive(1'b0, OP_NONE, 32'h0, 32'h0);

        // SH 0x3002
        tick();
        drive(1'b1, OP_SH, 32'h3002, 32'h0000_ABCD);
        tick();
        chk("sh_byteen", m_byteen, 4'b1100);
        chk("sh_wdata_hi", m_wdata[31:16], 16'hABCD);
        m_ack = 1'b1;
        tick();
        m_ack = 1'b0;
        tick();
        drive(1'b0, OP_NONE, 32'h0, 32'h0);

        // Misaligned LH / SW
        tick();
        drive(1'b1, OP_LH, 32'h4001, 32'h0);
        chk("adel_flag", exc_adel, 1);
        chk("adel_ades", exc_ades, 0);
        chk("adel_stall", stall, 0);
        tick();
        chk("adel_m_req", m_req, 0);
        drive(1'b1, OP_SW, 32'h4002, 32'h1234_5678);
        chk("ades_flag", exc_ades, 1);
        chk("ades_adel", exc_adel, 0);
        chk("ades_stall", stall, 0);
        tick();
        chk("ades_m_req", m_req, 0);
        drive(1'b0, OP_NONE, 32'h0, 32'h0);

        // LW without ack: timeout after 4 WAIT cycles
        tick();
        drive(1'b1, OP_LW, 32'h5000, 32'h0);
        tick();
        for (int c = 1; c <= 4; c++) begin
            chk($sformatf("to_c%0d_m_req", c), m_req, 1);
            chk($sformatf("to_c%0d_exc_bus", c), exc_bus, 0);
            tick();
        end
        chk("to_c5_m_req", m_req, 0);
        chk("to_c5_exc_bus", exc_bus, 1);
        chk("to_c5_rd_valid", rd_valid, 0);
        chk("to_c5_stall", stall, 0);
        tick();
        drive(1'b0, OP_NONE, 32'h0, 32'h0);
        chk("to_c6_exc_bus", exc_bus, 0);
        chk("to_c6_stall", stall, 0);

        // Reset during WAIT cycle 2, late ack ignored
        tick();
        drive(1'b1, OP_LW, 32'h7000, 32'h0);
        tick();
        tick();
        chk("rw_c2_m_req", m_req, 1);
        reset = 1'b1;
        #1;
        chk("rw_async_m_req", m_req, 0);
        drive(1'b0, OP_NONE, 32'h0, 32'h0);
        tick();
        reset = 1'b0;
        m_ack = 1'b1;
        tick();
        m_ack = 1'b0;
        chk("rw_ack_m_req", m_req, 0);
        chk("rw_ack_rd_valid", rd_valid, 0);
        chk("rw_ack_stall", stall, 0);
        tick();
        chk("rw_post_rd_valid", rd_valid, 0);
        chk("rw_post_rd_data", rd_data, 0);

        // Back in IDLE: SB 0x8001 is accepted
        drive(1'b1, OP_SB, 32'h8001, 32'hA5A5_A55A);
        chk("sb_c0_stall", stall, 1);
        tick();
        chk("sb_c1_m_req", m_req, 1);
        chk("sb_c1_byteen", m_byteen, 4'b0010);
        chk("sb_c1_wdata", m_wdata[15:8], 8'h5A);
        chk("sb_c1_m_addr", m_addr, 32'h8000);
        m_ack = 1'b1;
        tick();
        m_ack = 1'b0;
        chk("sb_c2_rd_valid", rd_valid, 0);
        chk("sb_c2_m_req", m_req, 0);
        tick();
        drive(1'b0, OP_NONE, 32'h0, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Parametrised M-stage memory access unit for the pipelined MIPS CPU; successor to the combinational byte-enable/load-op decoder. It accepts one decoded load/store per instruction from the M stage, checks alignment, and drives a registered request/acknowledge transaction to a variable-latency data memory. It stalls the pipeline until the transaction completes, then returns sign- or zero-extended load data, raising address or bus-timeout exceptions.

## Interface
Parameters:
- DATA_W, 32, data bus width; legal values 32 or 64; lanes = DATA_W/8.
- ADDR_W, 32, byte address width.
- TIMEOUT, 255, maximum WAIT cycles before a bus error; must be ≥1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; one clock domain.
- req_valid  in  1  M stage holds a memory instruction.
- req_op  in  4  operation code (mem_pkg): NONE, LB, LBU, LH, LHU, LW, SB, SH, SW.
- req_addr  in  ADDR_W  byte address (ALU result).
- req_wdata  in  DATA_W  store data, LSB-justified.
- stall  out  1  freeze F/D/E/M stages.
- rd_valid  out  1  load result valid (one cycle).
- rd_data  out  DATA_W  extended load result.
- exc_adel / exc_ades  out  1 each  misaligned load / store.
- exc_bus  out  1  timeout, one-cycle pulse.
- m_req  out  1  bus request.
- m_we  out  1  write strobe, qualified by m_req.
- m_addr  out  ADDR_W  lane-aligned address (low log2(lanes) bits zero).
- m_byteen  out  DATA_W/8  active lane mask.
- m_wdata  out  DATA_W  store data shifted into lane position.
- m_ack  in  1  memory completion; m_rdata is valid in the same cycle.
- m_rdata  in  DATA_W  read data.

## Operation
- Alignment: halfword requires addr[0]=0; word requires addr[1:0]=0; byte accesses are always aligned. Lane offset = addr[log2(lanes)-1:0].
- byteen: byte = 1<<off; half = 3<<off; word = 4'hF<<off (64-bit bus: off ∈ {0,4}).
- wdata: store value replicated or shifted into off*8.
- FSM states are IDLE, WAIT, DONE.
- IDLE: a request is accepted when req_valid=1, op≠NONE and the address is aligned. On accept, register addr/byteen/wdata/we/op/offset, set m_req=1 next cycle, go to WAIT.
- IDLE, misaligned: assert exc_adel or exc_ades combinationally in the same cycle. No bus transaction is started, stall=0, state stays IDLE.
- WAIT: hold all m_* outputs stable while m_req=1. On m_ack, capture and extend m_rdata (loads only), clear m_req, go to DONE. Otherwise increment the counter; when the counter reaches TIMEOUT, clear m_req, pulse exc_bus in DONE, go to DONE.
- DONE: rd_valid=1 for loads without a bus error; rd_data held. stall=0. Always returns to IDLE next cycle, so the same instruction, still present, is not re-accepted.
- Extension: LB/LH sign-extend; LBU/LHU zero-extend; LW is the selected 32-bit word, sign-extended to DATA_W when DATA_W=64.
- m_ack outside WAIT is ignored.
- stall = (IDLE & accept) | WAIT.

## Timing
- Reset values: state=IDLE, counter=0, m_req=0, m_we=0, m_addr=0, m_byteen=0, m_wdata=0, rd_valid=0, rd_data=0, exc_bus=0. stall, exc_adel and exc_ades are 0 given req_valid=0.
- Reset mid-transaction: m_req drops immediately (asynchronously). An m_ack arriving later is ignored.
- Latency: accept in cycle 0, m_req first high in cycle 1. If m_ack arrives in cycle k≥1, DONE is cycle k+1. Stall covers cycles 0..k. Minimum total stall is 2 cycles.
- Timeout: with no ack, DONE occurs in cycle TIMEOUT+1.
- m_req is a register output; no combinational path exists from m_ack to m_req. stall has a combinational path from req_* inputs.

## Structure
- mem_pkg: op encoding enum, state enum, width helper functions (lanes, offset width).
- Sub-module load_extend: combinational lane select plus sign/zero extension (inputs: rdata, op, offset). It is instantiated once.
- Top level contains the FSM, timeout counter, request registers and alignment/byteen logic.

## Test plan
- SW addr=0x1004 data=0xDEADBEEF, ack in cycle 1 → m_byteen=4'b1111, m_addr=0x1004, m_we=1; stall high cycles 0–1; DONE in cycle 2; rd_valid=0.
- LB addr=0x2003, m_rdata=0x80123456, ack after 3 cycles → rd_data=0xFFFFFF80, rd_valid for 1 cycle. Repeat with LBU → 0x00000080.
- SH addr=0x3002 data=0x0000ABCD → m_byteen=4'b1100, m_wdata[31:16]=0xABCD.
- LH addr=0x4001 → exc_adel=1 same cycle, m_req never rises, stall=0. SW addr=0x4002 → exc_ades=1.
- LW with no ack, TIMEOUT=4 → m_req high cycles 1–4, exc_bus pulse in cycle 5, rd_valid=0, then IDLE.
- Reset asserted in WAIT cycle 2, then m_ack pulsed after release → m_req=0 immediately, no rd_valid, state IDLE.
